memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 155 +++++++++++++++
 tb/tb_memory_cycle.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// memory_cycle: MEM pipeline stage with a word-only data-memory handshake, a
// 16-cycle wait timeout, misalignment detection and the MEM/WB register.
`default_nettype none

module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        Reg_WriteM,
  input  logic        Mem_WriteM,
  input  logic        Result_SrcM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] Write_DataM,
  input  logic [31:0] PcPlusM,
  input  logic [4:0]  RDM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        Stall_M,
  output logic        Reg_WriteW,
  output logic        Result_SrcW,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PcPlusW,
  output logic [4:0]  RDW,
  output logic        Misalign_W,
  output logic        Bus_ErrW
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [3:0] C_CNT_MAX = 4'd15;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic        r_we, r_reg_write, r_result_src;
  logic [31:0] r_addr, r_wdata, r_pc_plus;
  logic [4:0]  r_rd;

  logic        w_mem_op, w_aligned;
  logic        w_capture, w_complete, w_misalign, w_bus_err;
  logic        w_src_we, w_src_reg_write, w_src_result_src;
  logic [31:0] w_src_alu, w_src_pc;
  logic [4:0]  w_src_rd;

  assign w_mem_op  = Mem_WriteM | Result_SrcM;
  assign w_aligned = (ALU_ResultM[1:0] == 2'b00);

  // A completing access comes from the live EX/MEM inputs in IDLE and from
  // the hold registers once the request has been parked in WAIT.
  assign w_src_we         = (r_state == WAIT) ? r_we         : Mem_WriteM;
  assign w_src_reg_write  = (r_state == WAIT) ? r_reg_write  : Reg_WriteM;
  assign w_src_result_src = (r_state == WAIT) ? r_result_src : Result_SrcM;
  assign w_src_alu        = (r_state == WAIT) ? r_addr       : ALU_ResultM;
  assign w_src_pc         = (r_state == WAIT) ? r_pc_plus    : PcPlusM;
  assign w_src_rd         = (r_state == WAIT) ? r_rd         : RDM;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    dmem_req    = 1'b0;
    dmem_we     = Mem_WriteM;
    dmem_addr   = ALU_ResultM;
    dmem_wdata  = Write_DataM;
    Stall_M     = 1'b0;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_misalign  = 1'b0;
    w_bus_err   = 1'b0;

    case (r_state)
      IDLE: begin
        dmem_req = w_mem_op & w_aligned;
        if (w_mem_op && !w_aligned) begin
          w_misalign = 1'b1;
        end else if (w_mem_op && !dmem_ack) begin
          Stall_M     = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_complete = 1'b1;
        end
      end
      WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = r_addr;
        dmem_wdata = r_wdata;
        Stall_M    = ~dmem_ack & (r_cnt != C_CNT_MAX);
        // ack wins over timeout when both land on the last wait cycle
        if (dmem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == C_CNT_MAX) begin
          w_bus_err   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_pc_plus    <= 32'd0;
      r_rd         <= 5'd0;
      Reg_WriteW   <= 1'b0;
      Result_SrcW  <= 1'b0;
      ALU_ResultW  <= 32'd0;
      ReadDataW    <= 32'd0;
      PcPlusW      <= 32'd0;
      RDW          <= 5'd0;
      Misalign_W   <= 1'b0;
      Bus_ErrW     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_we         <= Mem_WriteM;
        r_reg_write  <= Reg_WriteM;
        r_result_src <= Result_SrcM;
        r_addr       <= ALU_ResultM;
        r_wdata      <= Write_DataM;
        r_pc_plus    <= PcPlusM;
        r_rd         <= RDM;
      end
      // Anything other than a completion loads a bubble.
      Reg_WriteW  <= w_complete & w_src_reg_write;
      Result_SrcW <= w_complete & w_src_result_src;
      ALU_ResultW <= w_complete ? w_src_alu : 32'd0;
      ReadDataW   <= (w_complete & w_src_result_src & ~w_src_we) ? dmem_rdata : 32'd0;
      PcPlusW     <= w_complete ? w_src_pc : 32'd0;
      RDW         <= w_complete ? w_src_rd : 5'd0;
      Misalign_W  <= w_misalign;
      Bus_ErrW    <= w_bus_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed and randomized transaction checks for memory_cycle.
`default_nettype none

module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        Reg_WriteM, Mem_WriteM, Result_SrcM;
  logic [31:0] ALU_ResultM, Write_DataM, PcPlusM;
  logic [4:0]  RDM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        Stall_M;
  logic        Reg_WriteW, Result_SrcW, Misalign_W, Bus_ErrW;
  logic [31:0] ALU_ResultW, ReadDataW, PcPlusW;
  logic [4:0]  RDW;

  int vectors = 0;
  int miscompares = 0;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .Reg_WriteM(Reg_WriteM), .Mem_WriteM(Mem_WriteM), .Result_SrcM(Result_SrcM),
    .ALU_ResultM(ALU_ResultM), .Write_DataM(Write_DataM), .PcPlusM(PcPlusM), .RDM(RDM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .Stall_M(Stall_M),
    .Reg_WriteW(Reg_WriteW), .Result_SrcW(Result_SrcW), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PcPlusW(PcPlusW), .RDW(RDW),
    .Misalign_W(Misalign_W), .Bus_ErrW(Bus_ErrW)
  );

  always #5 clk = ~clk;

  // MEM/WB view: {RegWrite, ResultSrc, ALU, ReadData, PcPlus, RD, Misalign, BusErr}
  logic [104:0] wb_got;
  assign wb_got = {Reg_WriteW, Result_SrcW, ALU_ResultW, ReadDataW, PcPlusW, RDW,
                   Misalign_W, Bus_ErrW};
  // Request view: {req, we, addr, wdata}
  logic [65:0] bus_got;
  assign bus_got = {dmem_req, dmem_we, dmem_addr, dmem_wdata};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One EX/MEM instruction; the memory acks on request cycle d (never if d > 16).
  task automatic do_op(input logic rw, input logic ws, input logic ls,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] rd, input int d);
    logic        memop, al;
    logic [31:0] rdat;
    logic [104:0] exp_wb;
    memop = ws | ls;
    al    = (a[1:0] == 2'b00);
    Reg_WriteM = rw; Mem_WriteM = ws; Result_SrcM = ls;
    ALU_ResultM = a; Write_DataM = wd; PcPlusM = pc; RDM = rd;
    if (!memop || !al) begin
      dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
      #1;
      chk("no_req", {127'd0, dmem_req}, 128'd0);
      chk("no_stall", {127'd0, Stall_M}, 128'd0);
      @(posedge clk); #1;
      if (!memop) exp_wb = {rw, 1'b0, a, 32'd0, pc, rd, 1'b0, 1'b0};
      else        exp_wb = {103'd0, 1'b1, 1'b0};
      chk(memop ? "wb_misalign" : "wb_alu", {23'd0, wb_got}, {23'd0, exp_wb});
    end else begin
      for (int k = 0; k <= 16; k++) begin
        dmem_ack = (k == d); dmem_rdata = $urandom; rdat = dmem_rdata;
        #1;
        chk("bus", {62'd0, bus_got}, {62'd0, 1'b1, ws, a, wd});
        chk("stall", {127'd0, Stall_M}, {127'd0, (k != d) && (k < 16)});
        @(posedge clk); #1;
        if (k == d) begin
          exp_wb = {rw, ls, a, ls ? rdat : 32'd0, pc, rd, 1'b0, 1'b0};
          chk("wb_done", {23'd0, wb_got}, {23'd0, exp_wb});
          break;
        end else if (k == 16) begin
          chk("wb_timeout", {23'd0, wb_got}, {23'd0, 103'd0, 1'b0, 1'b1});
          break;
        end else begin
          chk("wb_bubble", {23'd0, wb_got}, 128'd0);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, d;
    logic ws, ls;
    logic [31:0] a;
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    Reg_WriteM = 0; Mem_WriteM = 0; Result_SrcM = 0;
    ALU_ResultM = 0; Write_DataM = 0; PcPlusM = 0; RDM = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb", {23'd0, wb_got}, 128'd0);
    rst = 1'b1;

    do_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 32'h1004, 5'd5, 0);
    do_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h1008, 5'd7, 0);
    do_op(1'b0, 1'b1, 1'b0, 32'h200, 32'h12345678, 32'h100C, 5'd0, 3);
    do_op(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h1010, 5'd9, 99);
    do_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h1014, 5'd3, 0);
    do_op(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 32'h1018, 5'd4, 16);
    do_op(1'b1, 1'b0, 1'b1, 32'h404, 32'h0, 32'h101C, 5'd6, 15);

    // Reset while parked in WAIT abandons the access.
    Reg_WriteM = 1; Mem_WriteM = 0; Result_SrcM = 1; ALU_ResultM = 32'h500;
    PcPlusM = 32'h2000; RDM = 5'd8; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wait_stall", {127'd0, Stall_M}, {127'd0, 1'b1});
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1; dmem_ack = 1'b0;
    chk("rst_wb", {23'd0, wb_got}, 128'd0);
    Mem_WriteM = 0; Result_SrcM = 0;
    #1;
    chk("rst_idle_req", {127'd0, dmem_req}, 128'd0);
    do_op(1'b1, 1'b0, 1'b1, 32'h600, 32'h0, 32'h2004, 5'd2, 99);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      d = (r <= 5) ? r : (r == 6) ? 15 : (r == 7) ? 16 : (r == 8) ? 17 : 0;
      r = $urandom_range(0, 2);
      ws = (r == 2); ls = (r == 1);
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      do_op(1'($urandom), ws, ls, a, $urandom, $urandom, 5'($urandom), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
